pla_and_or_pipe: RTL and testbench

PLA_AND_OR_PIPE -- requirements
Module: pla_and_or_pipe

---
 rtl/pla_and_or_pipe.sv | 139 +++++++++++++
 tb/tb_pla_and_or_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_and_or_pipe.sv
// Configurable AND/OR PLA with a two-stage valid/ready pipeline.
// Stage 1 captures the product-term vector and a snapshot of the OR masks, so data in flight
// is unaffected by later configuration writes. Stage 2 holds the registered sums.
module pla_and_or_pipe #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_TERM = 2,
    parameter int unsigned N_OUT  = 1,
    localparam int unsigned AW    = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [N_IN-1:0]   cfg_and,
    input  logic [N_IN-1:0]   cfg_inv,
    input  logic [N_OUT-1:0]  cfg_or,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data,
    output logic [15:0]       eval_count
);

    logic [N_TERM-1:0][N_IN-1:0]  and_q, and_d;
    logic [N_TERM-1:0][N_IN-1:0]  inv_q, inv_d;
    logic [N_TERM-1:0][N_OUT-1:0] or_q, or_d;

    logic                         s1_valid_q, s1_valid_d;
    logic [N_TERM-1:0]            s1_term_q, s1_term_d;
    logic [N_TERM-1:0][N_OUT-1:0] s1_or_q, s1_or_d;

    logic                         out_valid_q, out_valid_d;
    logic [N_OUT-1:0]             out_data_q, out_data_d;
    logic [15:0]                  cnt_q, cnt_d;

    logic                         stall;
    logic                         addr_ok;
    logic [N_TERM-1:0]            term_c;
    logic [N_OUT-1:0]             sum_c;

    // Addresses beyond the last term exist only when N_TERM is not a power of two.
    if ((2 ** AW) > N_TERM) begin : g_addr_chk
        assign addr_ok = (cfg_addr < AW'(N_TERM));
    end else begin : g_addr_all
        assign addr_ok = 1'b1;
    end

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign eval_count = cnt_q;

    // Configuration write: one term per cycle, stall does not block it.
    always_comb begin
        and_d = and_q;
        inv_d = inv_q;
        or_d  = or_q;
        if (cfg_we && addr_ok) begin
            and_d[cfg_addr] = cfg_and;
            inv_d[cfg_addr] = cfg_inv;
            or_d[cfg_addr]  = cfg_or;
        end
    end

    // Product terms from the current masks; an empty AND mask yields 0 rather than 1.
    always_comb begin
        term_c = '0;
        for (int unsigned t = 0; t < N_TERM; t++) begin
            term_c[t] = (|and_q[t]) && (&((in_data ^ inv_q[t]) | ~and_q[t]));
        end
    end

    // Sums from the stage-1 terms and OR snapshot.
    always_comb begin
        sum_c = '0;
        for (int unsigned t = 0; t < N_TERM; t++) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                sum_c[k] = sum_c[k] | (s1_term_q[t] & s1_or_q[t][k]);
            end
        end
    end

    // Pipeline advance: both stages freeze together on stall, bubbles move like data.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_term_d   = s1_term_q;
        s1_or_d     = s1_or_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            s1_valid_d  = in_valid;
            if (in_valid) begin
                s1_term_d = term_c;
                s1_or_d   = or_q;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sum_c;
            end
        end
    end

    // Saturating count of delivered results.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q       <= '0;
            inv_q       <= '0;
            or_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_term_q   <= '0;
            s1_or_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            and_q       <= and_d;
            inv_q       <= inv_d;
            or_q        <= or_d;
            s1_valid_q  <= s1_valid_d;
            s1_term_q   <= s1_term_d;
            s1_or_q     <= s1_or_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pla_and_or_pipe.sv
// Directed bench for pla_and_or_pipe at default parameters; in_data = {c, b, a}.
module tb_pla_and_or_pipe;

    localparam int unsigned N_IN   = 3;
    localparam int unsigned N_TERM = 2;
    localparam int unsigned N_OUT  = 1;
    localparam int unsigned AW     = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [N_IN-1:0]   cfg_and = '0;
    logic [N_IN-1:0]   cfg_inv = '0;
    logic [N_OUT-1:0]  cfg_or = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_IN-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N_OUT-1:0]  out_data;
    logic [15:0]       eval_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic             mon_en = 1'b0;
    logic [N_OUT-1:0] mon_q[$];

    pla_and_or_pipe #(
        .N_IN   (N_IN),
        .N_TERM (N_TERM),
        .N_OUT  (N_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_and    (cfg_and),
        .cfg_inv    (cfg_inv),
        .cfg_or     (cfg_or),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .eval_count (eval_count)
    );

    always #5 clk = ~clk;

    // Record results that will be handshaken on the coming rising edge.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) mon_q.push_back(out_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_eval_count", 32'(eval_count), 32'd0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic write_cfg(input logic [AW-1:0] a, input logic [2:0] am, input logic [2:0] im,
                             input logic om);
        cfg_we = 1'b1; cfg_addr = a; cfg_and = am; cfg_inv = im; cfg_or = om;
        step();
        cfg_we = 1'b0;
    endtask

    // Accept one vector and check the result two edges after acceptance.
    task automatic run_one(input string tag, input logic [2:0] d, input logic exp);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        step();
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq(tag, 32'(out_data), 32'(exp));
    endtask

    // Offer one vector and hold it until accepted, bounded.
    task automatic drive(input logic [2:0] d);
        bit ok = 1'b0;
        bit acc;
        int n = 0;
        in_valid = 1'b1; in_data = d;
        while (!ok && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) ok = 1'b1;
            n++;
        end
        check_eq("bp_drive_accepted", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // All masks zero after reset: output is 0 regardless of input.
        run_one("zero_111", 3'b111, 1'b0);
        run_one("zero_000", 3'b000, 1'b0);

        // out = (a & b) | c
        write_cfg(1'b0, 3'b011, 3'b000, 1'b1);
        write_cfg(1'b1, 3'b100, 3'b000, 1'b1);
        run_one("sop_011", 3'b011, 1'b1);
        run_one("sop_000", 3'b000, 1'b0);
        run_one("sop_100", 3'b100, 1'b1);
        run_one("sop_111", 3'b111, 1'b1);
        run_one("sop_010", 3'b010, 1'b0);
        step();
        check_eq("count_after_7", 32'(eval_count), 32'd7);

        // out = ~a; t1 has an empty AND mask but still feeds the output.
        write_cfg(1'b0, 3'b001, 3'b001, 1'b1);
        write_cfg(1'b1, 3'b000, 3'b000, 1'b1);
        run_one("inv_000", 3'b000, 1'b1);
        run_one("inv_001", 3'b001, 1'b0);
        run_one("inv_110", 3'b110, 1'b1);
        run_one("inv_111", 3'b111, 1'b0);

        // Backpressure with a configuration write during the stall.
        do_reset();
        write_cfg(1'b0, 3'b001, 3'b001, 1'b1);
        write_cfg(1'b1, 3'b000, 3'b000, 1'b1);
        out_ready = 1'b0;
        mon_en = 1'b1;
        fork
            begin
                drive(3'b000);
                drive(3'b001);
                drive(3'b001);
            end
            begin
                step(); step(); step();
                check_eq("bp_in_ready_stalled", 32'(in_ready), 32'd0);
                check_eq("bp_out_valid_held", 32'(out_valid), 32'd1);
                check_eq("bp_out_data_held", 32'(out_data), 32'd1);
                cfg_we = 1'b1; cfg_addr = 1'b1; cfg_and = 3'b001; cfg_inv = 3'b000;
                cfg_or = 1'b1;
                step();
                cfg_we = 1'b0;
                step();
                check_eq("bp_in_ready_still", 32'(in_ready), 32'd0);
                check_eq("bp_out_data_stable", 32'(out_data), 32'd1);
                out_ready = 1'b1;
            end
        join
        repeat (5) step();
        mon_en = 1'b0;
        check_eq("bp_count_items", 32'(mon_q.size()), 32'd3);
        if (mon_q.size() == 3) begin
            check_eq("bp_item0", 32'(mon_q[0]), 32'd1);
            check_eq("bp_item1", 32'(mon_q[1]), 32'd0);
            check_eq("bp_item2", 32'(mon_q[2]), 32'd1);
        end
        check_eq("bp_eval_count", 32'(eval_count), 32'd3);

        // Reconfiguration on the same edge as an acceptance.
        do_reset();
        write_cfg(1'b0, 3'b011, 3'b000, 1'b1);
        write_cfg(1'b1, 3'b100, 3'b000, 1'b1);
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_and = 3'b000; cfg_inv = 3'b000; cfg_or = 1'b1;
        in_valid = 1'b1; in_data = 3'b011;
        step();
        cfg_we = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("reconf_old_valid", 32'(out_valid), 32'd1);
        check_eq("reconf_old_cfg", 32'(out_data), 32'd1);
        step();
        check_eq("reconf_new_valid", 32'(out_valid), 32'd1);
        check_eq("reconf_new_cfg", 32'(out_data), 32'd0);
        run_one("reconf_t1_kept", 3'b100, 1'b1);

        // Reset with two items in flight.
        do_reset();
        write_cfg(1'b1, 3'b100, 3'b000, 1'b1);
        in_valid = 1'b1; in_data = 3'b100;
        step();
        in_data = 3'b101;
        step();
        in_valid = 1'b0;
        check_eq("flight_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("flight_async_valid", 32'(out_valid), 32'd0);
        check_eq("flight_async_data", 32'(out_data), 32'd0);
        check_eq("flight_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("flight_no_ghost", 32'(out_valid), 32'd0);
        end
        check_eq("flight_eval_count", 32'(eval_count), 32'd0);
        run_one("flight_masks_clr", 3'b100, 1'b0);

        // Saturation of eval_count.
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (65536) step();
        check_eq("sat_fffe", 32'(eval_count), 32'h0000_FFFE);
        repeat (10) step();
        check_eq("sat_ffff", 32'(eval_count), 32'h0000_FFFF);
        check_eq("sat_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
